// File: rtl/qft3_measure_unit_pkg.sv
// Shared widths, counts and FSM encoding for the QFT measurement unit.
package qft3_measure_unit_pkg;
    localparam int TOTAL_WIDTH  = 8;
    localparam int PIPE_LATENCY = 26;
    localparam int MAG_W        = 2 * TOTAL_WIDTH;
    localparam int IDX_W        = 3;
    localparam int N_BASIS      = 8;
    localparam int SUM_W        = MAG_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } meas_state_t;
endpackage

// File: rtl/qft3_measure_unit_mag_sq.sv
// Combinational |a|^2 of a signed S3.4 complex value, exact for (-128)^2.
module qft_mag_sq
    import qft3_measure_unit_pkg::*;
(
    input  logic signed [TOTAL_WIDTH-1:0] i_re,
    input  logic signed [TOTAL_WIDTH-1:0] i_im,
    output logic        [MAG_W-1:0]       o_mag
);
    logic signed [MAG_W-1:0] w_re_x;
    logic signed [MAG_W-1:0] w_im_x;
    logic signed [MAG_W-1:0] w_re_sq;
    logic signed [MAG_W-1:0] w_im_sq;

    assign w_re_x  = MAG_W'(i_re);
    assign w_im_x  = MAG_W'(i_im);
    assign w_re_sq = w_re_x * w_re_x;
    assign w_im_sq = w_im_x * w_im_x;
    // Each square is at most 16384, so the unsigned sum (max 32768) fits MAG_W.
    assign o_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);
endmodule

// File: rtl/qft3_measure_unit.sv
// Measurement stage after the QFT core: snapshot, sequential argmax of |a|^2.
// Optional total-energy accumulator enabled by defining QFT_MEAS_ENERGY_EN.
module qft3_measure_unit
    import qft3_measure_unit_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [TOTAL_WIDTH-1:0] f000_r,
    input  logic signed [TOTAL_WIDTH-1:0] f000_i,
    input  logic signed [TOTAL_WIDTH-1:0] f001_r,
    input  logic signed [TOTAL_WIDTH-1:0] f001_i,
    input  logic signed [TOTAL_WIDTH-1:0] f010_r,
    input  logic signed [TOTAL_WIDTH-1:0] f010_i,
    input  logic signed [TOTAL_WIDTH-1:0] f011_r,
    input  logic signed [TOTAL_WIDTH-1:0] f011_i,
    input  logic signed [TOTAL_WIDTH-1:0] f100_r,
    input  logic signed [TOTAL_WIDTH-1:0] f100_i,
    input  logic signed [TOTAL_WIDTH-1:0] f101_r,
    input  logic signed [TOTAL_WIDTH-1:0] f101_i,
    input  logic signed [TOTAL_WIDTH-1:0] f110_r,
    input  logic signed [TOTAL_WIDTH-1:0] f110_i,
    input  logic signed [TOTAL_WIDTH-1:0] f111_r,
    input  logic signed [TOTAL_WIDTH-1:0] f111_i,
    output logic                          meas_valid,
    output logic        [IDX_W-1:0]       meas_index,
    output logic        [MAG_W-1:0]       meas_prob,
    output logic        [SUM_W-1:0]       total_energy,
    output logic                          busy,
    output logic                          overrun
);
    logic        [PIPE_LATENCY-1:0] r_dly;
    logic                           w_cap_strobe;
    meas_state_t                    r_state;
    meas_state_t                    w_state_nxt;
    logic        [IDX_W-1:0]        r_cnt;
    logic signed [TOTAL_WIDTH-1:0]  w_f_r    [N_BASIS];
    logic signed [TOTAL_WIDTH-1:0]  w_f_i    [N_BASIS];
    logic signed [TOTAL_WIDTH-1:0]  r_snap_r [N_BASIS];
    logic signed [TOTAL_WIDTH-1:0]  r_snap_i [N_BASIS];
    logic signed [TOTAL_WIDTH-1:0]  w_sel_r;
    logic signed [TOTAL_WIDTH-1:0]  w_sel_i;
    logic        [MAG_W-1:0]        w_mag;
    logic        [MAG_W-1:0]        r_best;
    logic        [IDX_W-1:0]        r_idx;
    logic                           w_take_best;
    logic                           w_capture;
    logic                           r_meas_valid;
    logic        [IDX_W-1:0]        r_meas_index;
    logic        [MAG_W-1:0]        r_meas_prob;
    logic                           r_overrun;

    always_comb begin
        w_f_r[0] = f000_r;  w_f_i[0] = f000_i;
        w_f_r[1] = f001_r;  w_f_i[1] = f001_i;
        w_f_r[2] = f010_r;  w_f_i[2] = f010_i;
        w_f_r[3] = f011_r;  w_f_i[3] = f011_i;
        w_f_r[4] = f100_r;  w_f_i[4] = f100_i;
        w_f_r[5] = f101_r;  w_f_i[5] = f101_i;
        w_f_r[6] = f110_r;  w_f_i[6] = f110_i;
        w_f_r[7] = f111_r;  w_f_i[7] = f111_i;
    end

    // Valid tag follows the core's fixed latency; the last tap marks the capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dly <= '0;
        else        r_dly <= {r_dly[PIPE_LATENCY-2:0], in_valid};
    end
    assign w_cap_strobe = r_dly[PIPE_LATENCY-1];
    assign w_capture    = (r_state == ST_IDLE) && w_cap_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cap_strobe) w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_cnt == IDX_W'(N_BASIS - 1)) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sel_r = r_snap_r[r_cnt];
    assign w_sel_i = r_snap_i[r_cnt];

    qft_mag_sq u_mag_sq (
        .i_re  (w_sel_r),
        .i_im  (w_sel_i),
        .o_mag (w_mag)
    );

    // Strict compare keeps the lowest index on ties; index 0 always seeds the search.
    assign w_take_best = (r_cnt == '0) || (w_mag > r_best);

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < N_BASIS; k++) begin
                r_snap_r[k] <= w_f_r[k];
                r_snap_i[k] <= w_f_i[k];
            end
            r_best <= '0;
            r_idx  <= '0;
        end else if ((r_state == ST_SCAN) && w_take_best) begin
            r_best <= w_mag;
            r_idx  <= r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_meas_valid <= 1'b0;
            r_meas_index <= '0;
            r_meas_prob  <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_meas_valid <= (r_state == ST_DONE);
            if (r_state == ST_SCAN) r_cnt <= r_cnt + 1'b1;
            else                    r_cnt <= '0;
            if (r_state == ST_DONE) begin
                r_meas_index <= r_idx;
                r_meas_prob  <= r_best;
            end
            if (w_cap_strobe && (r_state != ST_IDLE)) r_overrun <= 1'b1;
        end
    end

`ifdef QFT_MEAS_ENERGY_EN
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] r_total;

    always_ff @(posedge clk) begin
        if (w_capture)                 r_sum <= '0;
        else if (r_state == ST_SCAN)   r_sum <= r_sum + SUM_W'(w_mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_total <= '0;
        else if (r_state == ST_DONE)   r_total <= r_sum;
    end
    assign total_energy = r_total;
`else
    assign total_energy = '0;
`endif

    assign meas_valid = r_meas_valid;
    assign meas_index = r_meas_index;
    assign meas_prob  = r_meas_prob;
    assign busy       = (r_state != ST_IDLE);
    assign overrun    = r_overrun;
endmodule
